fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-stage producer for the F/D pipeline register: owns the PC, issues reads on the SRAM-like
//  instruction port (one outstanding request), and presents pcF, pc_plus4F, instrF and the
//  delay-slot flag F_change to Fetch_Decode. Handles branch/exception redirects, cancellation
//  of in-flight reads, and holding a returned instruction while the pipeline stalls.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   PC loaded on reset
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-low
//  stallF         in   1   hazard-unit stall excluding inst_stall; instruction not consumed
//  branchD        in   1   instr now in D is a branch/jump, so the instr in F is its delay slot
//  br_taken       in   1   taken redirect from D, valid 1 cycle
//  br_target      in   32  branch target
//  exc_flush      in   1   exception/eret redirect, valid 1 cycle, overrides br_taken
//  exc_target     in   32  exception/eret target
//  inst_req       out  1   read request
//  inst_addr      out  32  word address, stable while inst_req=1 and ~inst_addr_ok
//  inst_addr_ok   in   1   request accepted
//  inst_data_ok   in   1   read data valid
//  inst_rdata     in   32  read data
//  pcF            out  32  PC of presented instruction
//  pc_plus4F      out  32  pcF+4
//  instrF         out  32  instruction, 0 when ~validF or adelF
//  F_change       out  1   presented instruction is in a delay slot
//  validF         out  1   pcF/instrF hold a real instruction
//  adelF          out  1   pcF[1:0]!=0, no memory read issued
//  inst_stall     out  1   = ~validF; hazard unit ORs it into the F/D stall
// BEHAVIOUR
//  Reset (async, rst=0): pc=RESET_PC, state=IDLE, inst_req=0, validF=0, instrF=0, adelF=0,
//   F_change=0, cancel=0, redir_pend=0. First request issued the cycle after reset release.
//  fire = validF & ~stallF: the instruction is consumed; next PC selected that same edge.
//  States: IDLE -> REQ (issue) -> WAIT (addr_ok seen) -> HOLD (data_ok, validF=1) -> REQ on fire.
//   REQ: inst_req=1, inst_addr=pc; addr_ok -> WAIT. addr_ok & data_ok same cycle -> HOLD.
//   WAIT: data_ok -> latch rdata, validF=1, HOLD. Min latency REQ->validF: 1 cycle after data_ok.
//   HOLD: fire & ~misaligned next pc -> REQ next pc (req asserted cycle after fire).
//  Next PC: exc_flush ? exc_target : redir_pend/br_taken ? target : pc+4.
//  Branch redirect: delay slot (instr in F/in flight) is kept; br_taken latched into redir_pend
//   + target, applied when that delay slot fires. Not cleared by stalls.
//  Exception redirect: any state. HOLD/IDLE: drop validF, go REQ exc_target next cycle.
//   REQ before addr_ok: request held (addr stable); on addr_ok set cancel. WAIT: set cancel.
//   data_ok with cancel=1: data discarded, cancel cleared, REQ exc_target. redir_pend cleared.
//   exc_flush and br_taken same cycle: exception wins, branch dropped.
//  F_change: latched with the instruction = branchD at the cycle it fires from HOLD into D;
//   precisely, F_change = branchD (combinational pass-through gated by validF), 0 after exc.
//  Misaligned pc: no request; enter HOLD with validF=1, adelF=1, instrF=0 so D raises AdEL.
//  pc_plus4F wraps mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//  At most one request outstanding; inst_req never asserted in WAIT.
// STRUCTURE
//  Shared package (mips_defs): RESET_PC default, fetch state enum {IDLE,REQ,WAIT,HOLD},
//   NOP constant 32'h0. One sub-module is natural: fetch_next_pc (combinational next-PC
//   priority mux: exception > pending/branch > pc+4). Rest is a single FSM plus data latch.
// TESTING
//  1 Reset release, addr_ok=1 and data_ok 1 cycle later -> inst_addr=BFC00000, validF with
//    instrF=rdata, pc_plus4F=BFC00004; next request addr BFC00004 after fire.
//  2 stallF=1 for 5 cycles in HOLD -> pcF/instrF stable, inst_req=0, no second request.
//  3 br_taken target 0x80001000 while delay slot in WAIT -> delay slot presented with
//    F_change=1 (branchD=1), following request addr=0x80001000.
//  4 exc_flush target 0xBFC00380 in WAIT -> returned data dropped (validF stays 0), next
//    inst_addr=0xBFC00380; simultaneous br_taken ignored.
//  5 exc_target=0x80000002 -> no inst_req, validF=1, adelF=1, instrF=0.
//  6 Assert rst mid-WAIT -> outputs to reset values immediately; late data_ok ignored.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the fetch stage: reset vector, fetch FSM states and
// the bubble instruction word.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux for the fetch stage: exception redirect first, then a
// pending or same-cycle branch redirect, otherwise sequential pc+4.
module fetch_next_pc (
  input  logic [31:0] i_pc,
  input  logic        i_exc_flush,
  input  logic [31:0] i_exc_target,
  input  logic        i_redir_pend,
  input  logic [31:0] i_redir_target,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic [31:0] o_next_pc
);

  always_comb begin
    if (i_exc_flush)       o_next_pc = i_exc_target;
    else if (i_redir_pend) o_next_pc = i_redir_target;
    else if (i_br_taken)   o_next_pc = i_br_target;
    else                   o_next_pc = i_pc + 32'd4;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: issues single-outstanding instruction reads, holds the
// returned word until consumed, and applies branch/exception redirects.
module fetch_pc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        branchD,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic [31:0] exc_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic [31:0] instrF,
  output logic        F_change,
  output logic        validF,
  output logic        adelF,
  output logic        inst_stall
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_tgt;
  logic         r_valid;
  logic         r_adel;
  logic         r_cancel;
  logic         r_redir_pend;

  logic         w_fire;
  logic         w_drop;
  logic [31:0]  w_drop_tgt;
  logic [31:0]  w_next_pc;
  logic         w_load;
  logic [31:0]  w_load_pc;

  assign w_fire     = r_valid & ~stallF;
  // r_tgt doubles as the exception target once a cancel is armed.
  assign w_drop     = r_cancel | exc_flush;
  assign w_drop_tgt = exc_flush ? exc_target : r_tgt;

  fetch_next_pc u_next_pc (
    .i_pc           (r_pc),
    .i_exc_flush    (exc_flush),
    .i_exc_target   (exc_target),
    .i_redir_pend   (r_redir_pend),
    .i_redir_target (r_tgt),
    .i_br_taken     (br_taken),
    .i_br_target    (br_target),
    .o_next_pc      (w_next_pc)
  );

  // w_load: the PC is replaced this edge and a fresh fetch begins from it.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_load    = 1'b0;
    w_load_pc = w_next_pc;
    case (r_state)
      IDLE: begin
        w_load    = 1'b1;
        w_load_pc = exc_flush ? exc_target : r_pc;
      end
      REQ: begin
        if (inst_addr_ok && inst_data_ok && w_drop) begin
          w_load    = 1'b1;
          w_load_pc = w_drop_tgt;
        end
      end
      WAIT: begin
        if (inst_data_ok && w_drop) begin
          w_load    = 1'b1;
          w_load_pc = w_drop_tgt;
        end
      end
      HOLD:    w_load = exc_flush | w_fire;
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_tgt        <= '0;
      r_valid      <= 1'b0;
      r_adel       <= 1'b0;
      r_cancel     <= 1'b0;
      r_redir_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_load) begin
        r_pc     <= w_load_pc;
        r_instr  <= NOP;
        r_cancel <= 1'b0;
        if (misaligned(w_load_pc)) begin
          r_state <= HOLD;
          r_valid <= 1'b1;
          r_adel  <= 1'b1;
        end else begin
          r_state <= REQ;
          r_valid <= 1'b0;
          r_adel  <= 1'b0;
        end
      end else begin
        case (r_state)
          REQ: begin
            if (inst_addr_ok && inst_data_ok) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
              r_instr <= inst_rdata;
            end else if (inst_addr_ok) begin
              r_state <= WAIT;
            end
          end
          WAIT: begin
            if (inst_data_ok) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
              r_instr <= inst_rdata;
            end
          end
          default: r_state <= r_state;
        endcase
        // The request in flight cannot be withdrawn, so its data is marked for discard.
        if (exc_flush && (r_state == REQ || r_state == WAIT)) r_cancel <= 1'b1;
      end

      // A taken branch waits for its delay slot to be consumed before steering the PC.
      if (exc_flush) begin
        r_redir_pend <= 1'b0;
        r_tgt        <= exc_target;
      end else if (w_fire) begin
        r_redir_pend <= 1'b0;
      end else if (br_taken && !r_cancel) begin
        r_redir_pend <= 1'b1;
        r_tgt        <= br_target;
      end
    end
  end

  assign inst_req   = (r_state == REQ);
  assign inst_addr  = r_pc;
  assign pcF        = r_pc;
  assign pc_plus4F  = r_pc + 32'd4;
  assign instrF     = r_instr;
  assign F_change   = r_valid & branchD;
  assign validF     = r_valid;
  assign adelF      = r_adel;
  assign inst_stall = ~r_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed sequences, a table of redirect
// targets, and a randomized run against an instruction-stream reference model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        stallF, branchD, br_taken, exc_flush;
  logic [31:0] br_target, exc_target;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [31:0] pcF, pc_plus4F, instrF;
  logic        F_change, validF, adelF, inst_stall;

  int n_tests;
  int n_fail;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallF       (stallF),
    .branchD      (branchD),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .exc_flush    (exc_flush),
    .exc_target   (exc_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .pcF          (pcF),
    .pc_plus4F    (pc_plus4F),
    .instrF       (instrF),
    .F_change     (F_change),
    .validF       (validF),
    .adelF        (adelF),
    .inst_stall   (inst_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic        exp_req;
    logic        exp_adel;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[5];

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    br_taken     = 1'b0;
    exc_flush    = 1'b0;
  endtask

  // Random-phase state: reference model and memory responder.
  logic [31:0] exp_pc, ptgt, acc_addr, prev_addr;
  logic        pend, blk, busy, prev_hold;
  int          dwait, awt, fires, gap, max_gap, d;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; stallF = 1'b0; branchD = 1'b1;
    br_target = '0; exc_target = '0; inst_rdata = '0;
    clear_pulses();

    vecs[0] = '{32'h8000_0002, 1'b0, 1'b1, 32'h8000_0006};
    vecs[1] = '{32'h8000_0180, 1'b1, 1'b0, 32'h8000_0184};
    vecs[2] = '{32'h0000_0001, 1'b0, 1'b1, 32'h0000_0005};
    vecs[3] = '{32'h8000_0003, 1'b0, 1'b1, 32'h8000_0007};
    vecs[4] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0000};

    // Reset values (branchD high to show F_change is gated).
    tick(); tick(); #1;
    check("rst_req", inst_req, 0);
    check("rst_valid", validF, 0);
    check("rst_instr", instrF, 0);
    check("rst_adel", adelF, 0);
    check("rst_fchange", F_change, 0);
    check("rst_pc", pcF, RST_PC);
    check("rst_pc4", pc_plus4F, 32'hBFC0_0004);
    check("rst_stall", inst_stall, 1);

    // First fetch: addr_ok at once, data one cycle later.
    tick(); rst = 1'b1; branchD = 1'b0;
    tick();
    check("t1_req", inst_req, 1);
    check("t1_addr", inst_addr, RST_PC);
    inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0;
    check("t1_wait_req", inst_req, 0);
    check("t1_wait_valid", validF, 0);
    inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
    tick(); inst_data_ok = 1'b0;
    check("t1_valid", validF, 1);
    check("t1_instr", instrF, 32'h2408_0001);
    check("t1_pc", pcF, RST_PC);
    check("t1_pc4", pc_plus4F, 32'hBFC0_0004);
    check("t1_stall", inst_stall, 0);

    // Stall in HOLD: nothing moves, no new request.
    stallF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_pc", pcF, RST_PC);
      check("t2_instr", instrF, 32'h2408_0001);
      check("t2_req", inst_req, 0);
    end
    stallF = 1'b0;
    tick();
    check("t2_next_req", inst_req, 1);
    check("t2_next_addr", inst_addr, 32'hBFC0_0004);
    check("t2_next_valid", validF, 0);

    // Branch resolves while the delay slot is in WAIT.
    inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0;
    br_taken = 1'b1; br_target = 32'h8000_1000;
    tick(); br_taken = 1'b0;
    check("t3_wait_valid", validF, 0);
    inst_data_ok = 1'b1; inst_rdata = 32'h0000_0021;
    tick(); inst_data_ok = 1'b0;
    stallF = 1'b1; branchD = 1'b1; #1;
    check("t3_fchange", F_change, 1);
    check("t3_pc", pcF, 32'hBFC0_0004);
    check("t3_instr", instrF, 32'h0000_0021);
    stallF = 1'b0;
    tick();
    check("t3_fchange_gone", F_change, 0);
    check("t3_req", inst_req, 1);
    check("t3_target", inst_addr, 32'h8000_1000);
    branchD = 1'b0;

    // Exception in WAIT with a simultaneous branch: data dropped, branch ignored.
    inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0;
    exc_flush = 1'b1; exc_target = 32'hBFC0_0380;
    br_taken = 1'b1; br_target = 32'h1234_0000;
    tick(); clear_pulses();
    check("t4_req", inst_req, 0);
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    tick(); inst_data_ok = 1'b0;
    check("t4_dropped", validF, 0);
    check("t4_req2", inst_req, 1);
    check("t4_addr", inst_addr, 32'hBFC0_0380);
    inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0380;
    tick(); clear_pulses();
    check("t4_valid", validF, 1);
    check("t4_pc", pcF, 32'hBFC0_0380);
    check("t4_instr", instrF, 32'h0000_0380);
    tick();
    check("t4_seq_addr", inst_addr, 32'hBFC0_0384);

    // Land in HOLD, then apply each table redirect from HOLD.
    inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = memf(32'hBFC0_0384);
    stallF = 1'b1;
    tick(); clear_pulses();
    check("tab_pre_valid", validF, 1);
    for (int i = 0; i < 5; i++) begin
      exc_flush = 1'b1; exc_target = vecs[i].target;
      tick(); exc_flush = 1'b0;
      check("tab_req", inst_req, vecs[i].exp_req);
      check("tab_valid", validF, vecs[i].exp_adel);
      check("tab_adel", adelF, vecs[i].exp_adel);
      check("tab_instr0", instrF, 0);
      check("tab_pc", pcF, vecs[i].target);
      check("tab_pc4", pc_plus4F, vecs[i].exp_pc4);
      if (vecs[i].exp_req) begin
        check("tab_addr", inst_addr, vecs[i].target);
        inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = memf(vecs[i].target);
        tick(); clear_pulses();
        check("tab_served_valid", validF, 1);
        check("tab_served_instr", instrF, memf(vecs[i].target));
      end else begin
        tick();
        check("tab_adel_noreq", inst_req, 0);
        check("tab_adel_hold", validF, 1);
      end
    end

    // Wrap to 0, then reset mid-WAIT; late data must be ignored.
    stallF = 1'b0;
    tick();
    check("wrap_addr", inst_addr, 32'h0000_0000);
    check("wrap_req", inst_req, 1);
    inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0;
    #3; rst = 1'b0; #1;
    check("t6_req", inst_req, 0);
    check("t6_valid", validF, 0);
    check("t6_pc", pcF, RST_PC);
    check("t6_instr", instrF, 0);
    inst_data_ok = 1'b1; inst_rdata = 32'h0BAD_0BAD;
    tick(); rst = 1'b1;
    tick(); inst_data_ok = 1'b0;
    check("t6_req_after", inst_req, 1);
    check("t6_addr_after", inst_addr, RST_PC);
    check("t6_valid_after", validF, 0);
    tick();
    check("t6_still_waiting", validF, 0);

    // Randomized run against the instruction-stream model.
    rst = 1'b0; clear_pulses(); stallF = 1'b0; branchD = 1'b0;
    tick(); rst = 1'b1;
    exp_pc = RST_PC; pend = 1'b0; ptgt = '0; blk = 1'b0;
    busy = 1'b0; dwait = 0; awt = $urandom_range(0, 2); acc_addr = '0;
    prev_hold = 1'b0; prev_addr = '0;
    fires = 0; gap = 0; max_gap = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (busy) check("one_outstanding", inst_req, 0);
      if (prev_hold) begin
        check("req_held", inst_req, 1);
        check("addr_stable", inst_addr, prev_addr);
      end
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      if (busy) begin
        if (dwait == 0) begin
          inst_data_ok = 1'b1; inst_rdata = memf(acc_addr); busy = 1'b0;
        end else dwait--;
      end else if (inst_req) begin
        if (awt == 0) begin
          inst_addr_ok = 1'b1; acc_addr = inst_addr;
          d = $urandom_range(0, 2);
          if (d == 0) begin
            inst_data_ok = 1'b1; inst_rdata = memf(inst_addr);
          end else begin
            busy = 1'b1; dwait = d - 1;
          end
          awt = $urandom_range(0, 2);
        end else awt--;
      end
      prev_hold = inst_req & ~inst_addr_ok;
      prev_addr = inst_addr;

      stallF     = ($urandom_range(0, 3) == 0);
      branchD    = 1'($urandom_range(0, 1));
      exc_flush  = ($urandom_range(0, 39) == 0);
      exc_target = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      br_taken   = !blk && ($urandom_range(0, 7) == 0);
      br_target  = 32'h8001_0000 | ($urandom & 32'h0000_FFFC);
      #1;

      if (exc_flush) begin
        exp_pc = exc_target; pend = 1'b0; blk = 1'b1;
        gap++;
      end else if (validF && !stallF) begin
        fires++;
        check("rnd_pc", pcF, exp_pc);
        check("rnd_instr", instrF, memf(exp_pc));
        check("rnd_pc4", pc_plus4F, exp_pc + 32'd4);
        exp_pc = br_taken ? br_target : (pend ? ptgt : exp_pc + 32'd4);
        pend = 1'b0; blk = 1'b0; gap = 0;
      end else begin
        if (br_taken) begin
          pend = 1'b1; ptgt = br_target; blk = 1'b1;
        end
        gap++;
      end
      if (gap > max_gap) max_gap = gap;
    end
    check("rnd_progress", 32'(fires >= 200), 1);
    check("rnd_max_gap", 32'(max_gap < 100), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
